// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the branch predictor.
package branch_predictor_pkg;

    // Conditional branch opcode, for reference by the control path.
    localparam logic [6:0] OpcodeBranch = 7'b1100011;

    // RV32I conditional branch func3 encodings.
    localparam logic [2:0] Func3Beq  = 3'b000;
    localparam logic [2:0] Func3Bne  = 3'b001;
    localparam logic [2:0] Func3Blt  = 3'b100;
    localparam logic [2:0] Func3Bge  = 3'b101;
    localparam logic [2:0] Func3Bltu = 3'b110;
    localparam logic [2:0] Func3Bgeu = 3'b111;

    // Weakly-not-taken reset value: 2^(cnt_bits-1)-1, which is 0 for 1-bit counters.
    function automatic int unsigned cnt_init(int unsigned cnt_bits);
        return (32'd1 << (cnt_bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with asynchronous reset to a configurable value.
module sat_counter #(
    parameter int unsigned          CntBits = 2,
    parameter logic [CntBits-1:0]   InitVal = '0
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               en,
    input  logic               up,
    output logic [CntBits-1:0] value
);

    logic [CntBits-1:0] cnt_q, cnt_d;

    // Next value: step towards up/down, holding at either end instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (up && (cnt_q != {CntBits{1'b1}})) begin
                cnt_d = cnt_q + CntBits'(1);
            end else if (!up && (cnt_q != '0)) begin
                cnt_d = cnt_q - CntBits'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= InitVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped saturating-counter branch predictor with outcome resolution,
// misprediction flush and performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [31:0]          lookup_pc,
    output logic                 pred_taken,
    input  logic                 resolve_valid,
    input  logic [31:0]          resolve_pc,
    input  logic [2:0]           resolve_func3,
    input  logic                 resolve_pred,
    input  logic                 cmp_eq,
    input  logic                 cmp_lt,
    input  logic                 cmp_ltu,
    output logic                 actual_taken,
    output logic                 flush,
    input  logic                 stats_clr,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] mispredict_count
);

    localparam int unsigned Depth = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CntInit = CNT_BITS'(cnt_init(CNT_BITS));

    logic [IDX_BITS-1:0] lookup_idx, resolve_idx;
    logic [CNT_BITS-1:0] cnt [Depth];
    logic                legal_func3;
    logic                train;
    logic [STAT_BITS-1:0] branch_count_q, mispredict_count_q;

    // Word-aligned PCs: drop the byte offset before indexing.
    assign lookup_idx  = lookup_pc[IDX_BITS+1:2];
    assign resolve_idx = resolve_pc[IDX_BITS+1:2];

    // Tag-less table: PC bits above the index are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                              resolve_pc[31:IDX_BITS+2], resolve_pc[1:0]};

    // Read straight from the table; no bypass of a same-cycle update.
    assign pred_taken = cnt[lookup_idx][CNT_BITS-1];

    // Decode the branch outcome; unused func3 codes resolve as not taken and are ignored.
    always_comb begin
        legal_func3  = 1'b1;
        actual_taken = 1'b0;
        case (resolve_func3)
            Func3Beq:  actual_taken = cmp_eq;
            Func3Bne:  actual_taken = ~cmp_eq;
            Func3Blt:  actual_taken = cmp_lt;
            Func3Bge:  actual_taken = ~cmp_lt;
            Func3Bltu: actual_taken = cmp_ltu;
            Func3Bgeu: actual_taken = ~cmp_ltu;
            default:   legal_func3  = 1'b0;
        endcase
    end

    assign train = resolve_valid & legal_func3;
    assign flush = train & (actual_taken != resolve_pred);

    for (genvar i = 0; i < Depth; i++) begin : g_entry
        sat_counter #(
            .CntBits (CNT_BITS),
            .InitVal (CntInit)
        ) u_cnt (
            .clk    (clk),
            .arst_n (arst_n),
            .en     (train && (resolve_idx == IDX_BITS'(i))),
            .up     (actual_taken),
            .value  (cnt[i])
        );
    end

    // Performance counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (stats_clr) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (train) begin
            branch_count_q <= branch_count_q + STAT_BITS'(1);
            if (flush) begin
                mispredict_count_q <= mispredict_count_q + STAT_BITS'(1);
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
